// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a valid/ready byte output.
// Build option: define UART_RX_FIFO_EN to back the output with a
// 2^FIFO_DEPTH-entry show-ahead FIFO. Without it, the output is backed by a
// single holding register. Flags and handshake timing are the same in both builds.
module uart_rx_fifo #(
  parameter int UART_CLK_HZ        = 12000000,
  parameter int UART_SCLK_HZ       = 115200,
  parameter int UART_COUNTER_WIDTH = 9,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT  = UART_CLK_HZ / UART_SCLK_HZ;
  localparam int HALF = BIT / 2;
  localparam logic [UART_COUNTER_WIDTH-1:0] BIT_M1  = UART_COUNTER_WIDTH'(BIT - 1);
  localparam logic [UART_COUNTER_WIDTH-1:0] HALF_M1 = UART_COUNTER_WIDTH'(HALF - 1);
  localparam logic [UART_COUNTER_WIDTH-1:0] CNT_ONE = UART_COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                          rx_meta, rxs;
  state_t                        state, state_n;
  logic [UART_COUNTER_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]                    bit_idx, bit_idx_n;
  logic [7:0]                    shreg, shreg_n;
  logic                          push, ferr_evt, pop, accept;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state: sample mid-bit on cnt==0, LSB first; stop sample returns to IDLE.
  always_comb begin
    state_n   = state;
    cnt_n     = (state == S_IDLE) ? cnt : cnt - CNT_ONE;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n = S_START;
          cnt_n   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rxs) begin
            state_n   = S_DATA;
            cnt_n     = BIT_M1;
            bit_idx_n = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_n   = {rxs, shreg[7:1]};
          cnt_n     = BIT_M1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          push     = rxs;
          ferr_evt = !rxs;
          state_n  = S_IDLE;
          cnt_n    = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign pop = rx_valid & rx_ready;

`ifdef UART_RX_FIFO_EN
  localparam int ENTRIES = 1 << FIFO_DEPTH;

  logic [7:0]          mem [ENTRIES];
  logic [FIFO_DEPTH:0] wr_ptr, rd_ptr;
  logic                empty, full;

  // Extra MSB on the pointers separates full from empty.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[FIFO_DEPTH] != rd_ptr[FIFO_DEPTH]) &&
                  (wr_ptr[FIFO_DEPTH-1:0] == rd_ptr[FIFO_DEPTH-1:0]);
  // A pop in the same cycle frees the slot the push needs.
  assign accept = push & (!full | pop);

  // Pointer update; pops on an empty FIFO are already blocked by rx_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[FIFO_DEPTH-1:0]] <= shreg;
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[FIFO_DEPTH-1:0]];
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] hold_q;
  logic       hold_v;

  assign accept = push & (!hold_v | pop);

  // Single-entry holding register with a valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (accept) begin
      hold_q <= shreg;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end

  assign rx_valid = hold_v;
  assign rx_data  = hold_v ? hold_q : 8'h00;
`endif

  // One-cycle status pulses, aligned with the cycle a good byte would appear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_evt;
      overrun   <= push & !accept;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver for the sc1 SoC serial port. It sits on the `uart_rxd` pin, which `uart_txd` from the host drives.
- Deserialises 8N1 frames at the same `UART_CLK_HZ`/`UART_SCLK_HZ` rate as the SoC transmitter.
- Checks start and stop bits.
- Presents received bytes to the CPU I/O bus through a valid/ready handshake, backed by a small show-ahead FIFO.

## Interface
- `UART_CLK_HZ`, 12000000, system clock frequency in Hz.
- `UART_SCLK_HZ`, 115200, baud rate.
- `UART_COUNTER_WIDTH`, 9, bit-period counter width; must hold `UART_CLK_HZ/UART_SCLK_HZ - 1`.
- `FIFO_DEPTH`, 4, log2 of the FIFO entry count (16 entries); used only with `UART_RX_FIFO_EN`.
- `clk`  input  1  system clock; all logic rises on posedge.
- `reset`  input  1  asynchronous reset, active-low (0 = reset).
- `uart_rxd`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  byte at the FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  output  1  FIFO not empty.
- `rx_ready`  input  1  consumer pops the head when `rx_valid`&`rx_ready` at a clock edge.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  output  1  one-cycle pulse: complete byte dropped because storage was full.

## Operation
- **Bit timing:** BIT = `UART_CLK_HZ/UART_SCLK_HZ` (integer divide), HALF = BIT/2. Defaults give BIT=104, HALF=52.
- **Input synchroniser:** `uart_rxd` passes through a 2-flop synchroniser (reset value 1). All FSM decisions use the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP. The counter `cnt` decrements each cycle in non-IDLE states.
  - **IDLE:** when `rxs`=0, go to START with `cnt`=HALF-1.
  - **START:** at `cnt`=0, if `rxs`=0, go to DATA with `cnt`=BIT-1 and bit index 0. Otherwise go to IDLE (glitch rejected, no flags).
  - **DATA:** at `cnt`=0, shift `rxs` in LSB-first, then reload `cnt`=BIT-1. After bit 7, go to STOP.
  - **STOP:** at `cnt`=0, sample `rxs`. A 1 pushes the shift register into storage. A 0 pulses `frame_err` and discards the byte. Either way, go to IDLE on the same edge, so the next start edge can be detected from mid-stop-bit onward.
- **FIFO:** show-ahead (first-word fall-through). `rx_data` is the head entry; `rx_valid` = !empty.
- **Push while full:**
  - Without a same-cycle pop, the new byte is dropped and `overrun` pulses. Stored data is unchanged.
  - With a same-cycle pop, the push is accepted and no `overrun` occurs.
- **Pop while empty:** ignored.
- **Ordering:** bytes come out in arrival order. Pointers wrap modulo 2^`FIFO_DEPTH`. The full/empty distinction uses one extra pointer bit.
- **Reset:** asserting `reset` mid-frame aborts the frame without producing a byte or flag. It clears the FSM to IDLE, `cnt`=0, pointers=0, synchroniser=1.
- **Output values in reset:** `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0.

## Timing
- Synchroniser latency: 2 cycles.
- Sample points are HALF + k·BIT cycles after the synchronised falling edge: k=0 start, k=1..8 data, k=9 stop.
- **Push:** `rx_valid` rises on the edge after the stop-bit sample, 1 cycle later. Total latency from the line's falling edge is about 2 + HALF + 9·BIT + 1 cycles. At defaults that is 991 cycles.
- `frame_err`/`overrun` pulse in that same cycle and last exactly 1 cycle.
- **Pop:**
  - The next entry (or `rx_valid`=0) appears the cycle after a handshake.
  - Back-to-back pops at one per cycle are supported.
  - `rx_ready` may be held high permanently.
- Baud-rate tolerance is ±4% cumulative over the frame. No resynchronisation occurs mid-frame.

## Configuration
- **`UART_RX_FIFO_EN` defined:** storage is the 2^`FIFO_DEPTH`-entry FIFO described above.
- **`UART_RX_FIFO_EN` undefined:** storage is a single holding register plus a valid flag. `FIFO_DEPTH` is ignored.
  - A push with the flag set and no same-cycle pop drops the byte and pulses `overrun`.
  - Handshake timing, reset values and flag behaviour are identical to the FIFO build.

## Test plan
- **Single byte:** drive frame 0x55 at 104 cycles/bit with `rx_ready`=0. Required: `rx_valid`=1 with `rx_data`=0x55 at cycle 991±1 after the falling edge, and no flags. Raise `rx_ready` for one cycle → `rx_valid`=0.
- **Glitch:** drive a 20-cycle low pulse on an idle line. Required: FSM returns to IDLE, no `rx_valid`, no flags. A following 0xA3 frame is received correctly.
- **Framing error:** send 0x3C with the stop bit held 0 for one bit period, then the line idle. Required: one `frame_err` pulse, `rx_valid` stays 0. A next frame of 0x81 is received correctly.
- **Overrun, FIFO build:** with `rx_ready`=0, send 17 bytes 0x00..0x10 back-to-back. Required: the 17th byte pulses `overrun`. Draining at 1 pop/cycle yields exactly 0x00..0x0F, then `rx_valid`=0.
- **Full + simultaneous pop:** fill 16 entries, then pop on the exact push cycle of byte 0x20. Required: no `overrun`, and 0x20 appears last in the drain order. Repeat on the non-FIFO build with 1 entry.
- **Reset mid-frame:** pull `reset` low during data bit 4 of 0xFF, release, then send 0x42. Required: all outputs 0 during reset, no byte from the aborted frame, 0x42 received.
